// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared constants for the UART command sequencer: data width, opcodes,
// response byte, error codes and FSM state encoding.
package uart_cmd_ctrl_pkg;

  localparam int unsigned DATA_W = 8;

  localparam logic [DATA_W-1:0] CMD_WR    = 8'hAA;
  localparam logic [DATA_W-1:0] CMD_RD    = 8'hBB;
  localparam logic [DATA_W-1:0] CMD_PING  = 8'hCC;
  localparam logic [DATA_W-1:0] PING_RESP = 8'h55;

  localparam logic [2:0] ERR_CMD     = 3'b001;
  localparam logic [2:0] ERR_ADDR    = 3'b010;
  localparam logic [2:0] ERR_TIMEOUT = 3'b011;
  localparam logic [2:0] ERR_OVERRUN = 3'b100;

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_REQ, TX_ACK, TX_DONE
  } state_e;

  // States in which a new RX byte cannot be accepted.
  function automatic logic is_overrun_state(input state_e s);
    return s inside {RD_WAIT, TX_REQ, TX_ACK, TX_DONE};
  endfunction

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// UART RX/TX handshake and register-file port of the command sequencer.
// master = sequencer side, slave = UART pair / register file side.
interface uart_cmd_ctrl_if
  import uart_cmd_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH  = DATA_W,
  parameter int unsigned ADDR_W = 4
);
  logic [WIDTH-1:0]  rx_data_in;
  logic              rx_valid_in;
  logic              tx_busy_in;
  logic [WIDTH-1:0]  tx_data_out;
  logic              tx_valid_out;
  logic [ADDR_W-1:0] rf_addr_out;
  logic              rf_wr_en_out;
  logic [WIDTH-1:0]  rf_wr_data_out;
  logic              rf_rd_en_out;
  logic [WIDTH-1:0]  rf_rd_data_in;
  logic              rf_rd_valid_in;
  logic              busy_out;
  logic              err_out;
  logic [2:0]        err_code_out;

  modport master (
    input  rx_data_in, rx_valid_in, tx_busy_in, rf_rd_data_in, rf_rd_valid_in,
    output tx_data_out, tx_valid_out, rf_addr_out, rf_wr_en_out, rf_wr_data_out,
           rf_rd_en_out, busy_out, err_out, err_code_out
  );

  modport slave (
    output rx_data_in, rx_valid_in, tx_busy_in, rf_rd_data_in, rf_rd_valid_in,
    input  tx_data_out, tx_valid_out, rf_addr_out, rf_wr_en_out, rf_wr_data_out,
           rf_rd_en_out, busy_out, err_out, err_code_out
  );
endinterface

// File: rtl/uart_cmd_timeout.sv
// Per-state watchdog: cleared on state entry, counts while enabled, and
// flags expiry in the cycle the count reaches TIMEOUT-1.
module uart_cmd_timeout #(
  parameter int unsigned TIMEOUT = 50000,
  parameter int unsigned TO_W    = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  logic [TO_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       cnt_q <= '0;
    else if (clear)  cnt_q <= '0;
    else if (enable) cnt_q <= cnt_q + 1'b1;
  end

  assign expire = enable && (cnt_q == TO_W'(TIMEOUT - 1));
endmodule

// File: rtl/uart_cmd_ctrl.sv
// Command sequencer: parses RX byte frames into write/read/ping commands,
// drives the register-file port and returns single-byte responses over TX.
module uart_cmd_ctrl
  import uart_cmd_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = DATA_W,
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned TIMEOUT = 50000,
  parameter int unsigned TO_W    = 16
) (
  input logic             clk,
  input logic             reset,
  uart_cmd_ctrl_if.master bus
);
  state_e            state_q, state_d;
  logic [WIDTH-1:0]  tx_data_q, tx_data_d, wr_data_q, wr_data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        err_code_q, err_code_d;
  logic              tx_valid_q, tx_valid_d;
  logic              wr_en_q, wr_en_d;
  logic              rd_en_q, rd_en_d;
  logic              err_q, err_d;
  logic              advance, expire, addr_bad;

  assign addr_bad = |bus.rx_data_in[WIDTH-1:ADDR_W];

  uart_cmd_timeout #(
    .TIMEOUT(TIMEOUT),
    .TO_W   (TO_W)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clear (state_d != state_q),
    .enable(state_q != IDLE),
    .expire(expire)
  );

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    wr_data_d  = wr_data_q;
    addr_d     = addr_q;
    err_code_d = err_code_q;
    tx_valid_d = 1'b0;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    err_d      = 1'b0;
    advance    = 1'b0;

    unique case (state_q)
      IDLE: if (bus.rx_valid_in) begin
        advance = 1'b1;
        case (bus.rx_data_in)
          CMD_WR:   state_d = WR_ADDR;
          CMD_RD:   state_d = RD_ADDR;
          CMD_PING: begin
            tx_data_d = PING_RESP;
            state_d   = TX_REQ;
          end
          default: begin
            err_d      = 1'b1;
            err_code_d = ERR_CMD;
          end
        endcase
      end
      WR_ADDR: if (bus.rx_valid_in) begin
        advance = 1'b1;
        if (addr_bad) begin
          err_d      = 1'b1;
          err_code_d = ERR_ADDR;
          state_d    = IDLE;
        end else begin
          addr_d  = bus.rx_data_in[ADDR_W-1:0];
          state_d = WR_DATA;
        end
      end
      WR_DATA: if (bus.rx_valid_in) begin
        advance   = 1'b1;
        wr_en_d   = 1'b1;
        wr_data_d = bus.rx_data_in;
        state_d   = IDLE;
      end
      RD_ADDR: if (bus.rx_valid_in) begin
        advance = 1'b1;
        if (addr_bad) begin
          err_d      = 1'b1;
          err_code_d = ERR_ADDR;
          state_d    = IDLE;
        end else begin
          addr_d  = bus.rx_data_in[ADDR_W-1:0];
          rd_en_d = 1'b1;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: if (bus.rf_rd_valid_in) begin
        advance   = 1'b1;
        tx_data_d = bus.rf_rd_data_in;
        state_d   = TX_REQ;
      end
      TX_REQ: if (!bus.tx_busy_in) begin
        advance    = 1'b1;
        tx_valid_d = 1'b1;
        state_d    = TX_ACK;
      end
      TX_ACK: if (bus.tx_busy_in) begin
        advance = 1'b1;
        state_d = TX_DONE;
      end
      TX_DONE: if (!bus.tx_busy_in) begin
        advance = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Overrun only flags; a same-cycle timeout overrides its code and the state.
    if (bus.rx_valid_in && is_overrun_state(state_q)) begin
      err_d      = 1'b1;
      err_code_d = ERR_OVERRUN;
    end
    if (expire && !advance) begin
      state_d    = IDLE;
      err_d      = 1'b1;
      err_code_d = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      tx_data_q  <= '0;
      wr_data_q  <= '0;
      addr_q     <= '0;
      err_code_q <= '0;
      tx_valid_q <= 1'b0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      wr_data_q  <= wr_data_d;
      addr_q     <= addr_d;
      err_code_q <= err_code_d;
      tx_valid_q <= tx_valid_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      err_q      <= err_d;
    end
  end

  assign bus.tx_data_out    = tx_data_q;
  assign bus.tx_valid_out   = tx_valid_q;
  assign bus.rf_addr_out    = addr_q;
  assign bus.rf_wr_en_out   = wr_en_q;
  assign bus.rf_wr_data_out = wr_data_q;
  assign bus.rf_rd_en_out   = rd_en_q;
  assign bus.busy_out       = (state_q != IDLE);
  assign bus.err_out        = err_q;
  assign bus.err_code_out   = err_code_q;
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: directed RX frames push expected
// rf/tx/err events; a negedge monitor pops and compares them.
module tb_uart_cmd_ctrl;
  typedef enum logic [1:0] {EV_WR, EV_RD, EV_TX, EV_ERR} ev_kind_e;
  typedef struct packed {
    ev_kind_e   kind;
    logic [3:0] addr;
    logic [7:0] data;
  } ev_t;

  logic        clk        = 1'b0;
  logic        reset      = 1'b1;
  logic        hold_busy  = 1'b0;
  logic        model_busy = 1'b0;
  logic        rf_mute    = 1'b0;
  int unsigned n_cmp      = 0;
  int unsigned n_fail     = 0;
  ev_t         exp_q[$];
  logic [7:0]  rf_mem[16];

  uart_cmd_ctrl_if #(.WIDTH(8), .ADDR_W(4)) bus ();
  assign bus.tx_busy_in = hold_busy | model_busy;

  uart_cmd_ctrl #(
    .WIDTH  (8),
    .ADDR_W (4),
    .TIMEOUT(16),
    .TO_W   (5)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic void push(input ev_kind_e k, input logic [3:0] a, input logic [7:0] d);
    exp_q.push_back('{kind: k, addr: a, data: d});
  endfunction

  task automatic observe(input ev_t got);
    ev_t exp;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind=%0d addr=%h data=%h required none",
               got.kind, got.addr, got.data);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        n_fail++;
        $display("FAIL event: got kind=%0d addr=%h data=%h required kind=%0d addr=%h data=%h",
                 got.kind, got.addr, got.data, exp.kind, exp.addr, exp.data);
      end
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_data_in  = b;
    bus.rx_valid_in = 1'b1;
    step(1);
    bus.rx_valid_in = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int unsigned budget);
    int unsigned k = 0;
    while (bus.busy_out && k < budget) begin
      step(1);
      k++;
    end
    check(name, {31'd0, bus.busy_out}, 32'd0);
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.rf_wr_en_out) observe('{kind: EV_WR, addr: bus.rf_addr_out, data: bus.rf_wr_data_out});
        if (bus.rf_rd_en_out) observe('{kind: EV_RD, addr: bus.rf_addr_out, data: 8'h00});
        if (bus.tx_valid_out) begin
          observe('{kind: EV_TX, addr: 4'h0, data: bus.tx_data_out});
          check("tx_valid_while_busy", {31'd0, bus.tx_busy_in}, 32'd0);
        end
        if (bus.err_out) observe('{kind: EV_ERR, addr: 4'h0, data: {5'd0, bus.err_code_out}});
      end
    end
  end

  // Register-file model: read data two cycles after the strobe
  initial begin
    logic [3:0] a;
    bus.rf_rd_valid_in = 1'b0;
    bus.rf_rd_data_in  = 8'h00;
    for (int i = 0; i < 16; i++) rf_mem[i] = 8'(i * 17);
    rf_mem[7] = 8'hC3;
    forever begin
      @(negedge clk);
      if (bus.rf_rd_en_out && !rf_mute && !reset) begin
        a = bus.rf_addr_out;
        repeat (2) @(posedge clk);
        #1;
        bus.rf_rd_data_in  = rf_mem[a];
        bus.rf_rd_valid_in = 1'b1;
        @(posedge clk);
        #1;
        bus.rf_rd_valid_in = 1'b0;
      end
    end
  end

  // Transmitter model: busy for six cycles after each request
  initial begin
    forever begin
      @(negedge clk);
      if (bus.tx_valid_out && !reset) begin
        @(posedge clk);
        #1 model_busy = 1'b1;
        repeat (6) @(posedge clk);
        #1 model_busy = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned k;
    bus.rx_data_in  = 8'h00;
    bus.rx_valid_in = 1'b0;
    step(2);
    check("reset_outputs", {4'd0, bus.tx_valid_out, bus.tx_data_out, bus.rf_addr_out, bus.rf_wr_en_out,
                            bus.rf_wr_data_out, bus.rf_rd_en_out, bus.busy_out, bus.err_out,
                            bus.err_code_out}, 32'd0);
    reset = 1'b0;
    step(2);

    // Write
    push(EV_WR, 4'h3, 8'h5A);
    send(8'hAA); send(8'h03); send(8'h5A);
    check("wr_latency", {31'd0, bus.rf_wr_en_out}, 32'd1);
    wait_idle("wr_idle", 10);
    step(2);

    // Write to highest address
    push(EV_WR, 4'hF, 8'hA5);
    send(8'hAA); send(8'h0F); send(8'hA5);
    wait_idle("wr_max_idle", 10);
    step(2);

    // Read
    push(EV_RD, 4'h7, 8'h00);
    push(EV_TX, 4'h0, 8'hC3);
    send(8'hBB); send(8'h07);
    check("rd_latency", {31'd0, bus.rf_rd_en_out}, 32'd1);
    wait_idle("rd_idle", 40);
    step(2);

    // Unknown opcode
    push(EV_ERR, 4'h0, 8'h01);
    send(8'h12);
    check("unknown_stays_idle", {31'd0, bus.busy_out}, 32'd0);
    step(2);

    // Bad write address, no write
    push(EV_ERR, 4'h0, 8'h02);
    send(8'hAA); send(8'hF3);
    wait_idle("badwr_idle", 3);
    step(3);

    // Bad read address
    push(EV_ERR, 4'h0, 8'h02);
    send(8'hBB); send(8'h1F);
    wait_idle("badrd_idle", 3);
    step(3);

    // Ping while transmitter busy for 20 cycles
    push(EV_TX, 4'h0, 8'h55);
    hold_busy = 1'b1;
    step(7);
    send(8'hCC);
    step(12);
    check("ping_waiting", {31'd0, bus.busy_out}, 32'd1);
    hold_busy = 1'b0;
    wait_idle("ping_idle", 40);
    step(2);

    // Overrun during TX_DONE
    push(EV_TX, 4'h0, 8'h55);
    push(EV_ERR, 4'h0, 8'h04);
    send(8'hCC);
    k = 0;
    while (!bus.tx_busy_in && k < 20) begin
      step(1);
      k++;
    end
    check("ovr_tx_busy_seen", {31'd0, bus.tx_busy_in}, 32'd1);
    step(2);
    send(8'h77);
    check("ovr_state_kept", {31'd0, bus.busy_out}, 32'd1);
    wait_idle("ovr_idle", 40);
    step(2);

    // Timeout after AA with no further bytes
    push(EV_ERR, 4'h0, 8'h03);
    send(8'hAA);
    step(15);
    check("timeout_early", {31'd0, bus.err_out}, 32'd0);
    step(1);
    check("timeout_fire", {31'd0, bus.err_out}, 32'd1);
    check("timeout_idle", {31'd0, bus.busy_out}, 32'd0);
    step(3);

    // Reset while the read strobe is pending in RD_WAIT
    rf_mute = 1'b1;
    send(8'hBB); send(8'h05);
    check("rd_strobe_pre_reset", {31'd0, bus.rf_rd_en_out}, 32'd1);
    reset = 1'b1;
    #1;
    check("midreset_outputs", {4'd0, bus.tx_valid_out, bus.tx_data_out, bus.rf_addr_out, bus.rf_wr_en_out,
                               bus.rf_wr_data_out, bus.rf_rd_en_out, bus.busy_out, bus.err_out,
                               bus.err_code_out}, 32'd0);
    step(2);
    reset = 1'b0;
    step(1);
    rf_mute = 1'b0;
    push(EV_WR, 4'h1, 8'hFF);
    send(8'hAA); send(8'h01); send(8'hFF);
    wait_idle("post_reset_idle", 10);

    step(10);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
